obj_sensor_scheduler: RTL and testbench
=======================================

# obj_sensor_scheduler

Time-multiplexes one shared ranging unit across the four sensing directions (front, right, back, left). It runs the request/acknowledge/done handshake with that unit and compares each returned distance against a threshold. It debounces the per-direction hit results and drives the four presence lines `front_sensor`, `left_sensor`, `right_sensor` and `back_sensor` that feed the direction-decode logic. While an object is held in front, front is scanned more often.

## Interface
Parameters:
- `DIST_W`, 12: width of the distance bus.
- `TIMEOUT`, 1000: cycles allowed in WAIT before the measurement is abandoned.
- `GAP`, 16: idle cycles between measurements (echo settling). Must be ≥ 1.
- `DEBOUNCE`, 3: consecutive agreeing results needed to change a presence flag. Range 1–7.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset. Synchronous, active-high.
- `enable`, in, 1: run scanning.
- `threshold`, in, DIST_W: hit when `0 < dist < threshold`. Sampled at `rng_done`.
- `rng_req`, out, 1: measurement request to the ranging unit.
- `rng_sel`, out, 2: direction being measured. 0 = F, 1 = R, 2 = B, 3 = L.
- `rng_ack`, in, 1: ranging unit accepted the request.
- `rng_done`, in, 1: one-cycle pulse; `rng_dist` is valid in that cycle.
- `rng_dist`, in, DIST_W: measured distance.
- `front_sensor`, `right_sensor`, `back_sensor`, `left_sensor`, out, 1 each: debounced presence flags.
- `scan_done`, out, 1: one-cycle pulse when a left-slot result is committed (end of a round).
- `timeout_err`, out, 1: one-cycle pulse when a measurement times out.

## Operation
- FSM states: IDLE, REQ, WAIT, GAP.
- IDLE → REQ when `enable` = 1.
- REQ: `rng_req` = 1 and `rng_sel` is held stable. Leave for WAIT on the first cycle with `rng_ack` = 1.
- WAIT: timer counts from 0.
  - `rng_done` → commit the result and go to GAP.
  - Timer reaches `TIMEOUT`-1 without `rng_done` → commit a miss, pulse `timeout_err`, go to GAP.
  - `rng_done` and timeout in the same cycle → `rng_done` wins, no `timeout_err`.
- GAP: wait `GAP` cycles. Then advance the slot and go to REQ if `enable` = 1, else IDLE.
- `enable` dropping in REQ is honoured only once `rng_ack` arrives. The request is never withdrawn mid-handshake.
- `enable` dropping in WAIT or GAP lets the current measurement complete. The next transition is to IDLE.
- `rng_done` outside WAIT is ignored. So is `rng_ack` outside REQ. `rng_done` in the same cycle as `rng_ack` (in REQ) is ignored.
- Slot order, normal: F, R, B, L, then wrap.
- Slot order with `front_sensor` = 1 when the slot advances: F is inserted after every non-front slot, giving F, R, F, B, F, L, F, R, …
- The round position (R/B/L pointer) is preserved across inserted F slots and across IDLE.
- Reset restarts the round at F.
- Hit rule: `rng_dist != 0 && rng_dist < threshold`, unsigned compare. Distance 0 counts as a miss (invalid echo).
- Debounce, per direction: a 3-bit saturating counter of consecutive results that disagree with the current flag.
  - An agreeing result clears the counter.
  - When the counter reaches `DEBOUNCE`, the flag toggles and the counter clears.
  - Only the measured direction's counter changes.
- Reset (synchronous, including mid-handshake): state IDLE, `rng_req` = 0, `rng_sel` = 0, all flags 0, all counters 0, timer 0, `scan_done` = 0, `timeout_err` = 0.

## Timing
- `rng_req` rises the cycle after IDLE→REQ. It falls the cycle after `rng_ack` is sampled high.
- Flag update, `scan_done` and `timeout_err` are all registered: they appear one cycle after the `rng_done` / timeout cycle.
- Minimum measurement period: 1 (REQ) + 1 (WAIT, with `rng_done` on first cycle) + `GAP` cycles.
- Timeout occurs exactly `TIMEOUT` cycles after WAIT entry.

## Structure
- Package `obj_pkg` holds:
  - the direction encoding constants `DIR_F`, `DIR_R`, `DIR_B`, `DIR_L`;
  - the state typedef `sched_state_t`.
- Sub-module `obj_debounce` holds one flag and its counter, with inputs `upd` and `hit`. It is instantiated four times.

## Test plan
- `enable` = 1, `threshold` = 200, unit acks in 1 cycle and done after 5 cycles with dist = 500 on all → sequence `rng_sel` 0,1,2,3,0; all flags 0; `scan_done` pulses once per 4 measurements.
- Front dist = 100 three times → `front_sensor` rises after the 3rd front result. Slot order becomes F,R,F,B,F,L. Three front misses (dist = 300) → flag falls and order reverts.
- Front alternates hit/miss (DEBOUNCE = 3) → `front_sensor` stays 0.
- Unit never raises `rng_done` → `timeout_err` pulses exactly 1000 cycles after WAIT entry, counted as a miss, scanning continues with the next slot.
- `rng_done` on the timeout cycle with dist = 50 → no `timeout_err`, hit counted. `rng_dist` = 0 → miss. `rng_dist` = `threshold` → miss.
- `reset` asserted in WAIT → next cycle all outputs 0, state IDLE. `enable` dropped in GAP → finishes GAP, then IDLE with `rng_req` = 0. Re-enabling resumes at the preserved round position.

Source files
------------

// File: rtl/obj_sensor_scheduler_pkg.sv
// Shared encodings for the sensor scheduler: direction codes and FSM states.
package obj_pkg;

    localparam logic [1:0] DIR_F = 2'd0;
    localparam logic [1:0] DIR_R = 2'd1;
    localparam logic [1:0] DIR_B = 2'd2;
    localparam logic [1:0] DIR_L = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_GAP  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/obj_sensor_scheduler_if.sv
// Request/acknowledge/done handshake between the scheduler and the shared ranging unit.
interface obj_sensor_scheduler_if #(
    parameter int DIST_W = 12
);
    logic              rng_req;
    logic [1:0]        rng_sel;
    logic              rng_ack;
    logic              rng_done;
    logic [DIST_W-1:0] rng_dist;

    modport master (
        output rng_req,
        output rng_sel,
        input  rng_ack,
        input  rng_done,
        input  rng_dist
    );

    modport slave (
        input  rng_req,
        input  rng_sel,
        output rng_ack,
        output rng_done,
        output rng_dist
    );
endinterface

// File: rtl/obj_sensor_scheduler_debounce.sv
// One presence flag: toggles after DEBOUNCE consecutive results that disagree with it.
module obj_debounce #(
    parameter int DEBOUNCE = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic upd,
    input  logic hit,
    output logic flag
);
    logic       r_flag;
    logic [2:0] r_cnt;
    logic [3:0] w_cnt_inc;

    assign w_cnt_inc = {1'b0, r_cnt} + 4'd1;
    assign flag      = r_flag;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flag <= 1'b0;
            r_cnt  <= 3'd0;
        end else if (upd) begin
            if (hit == r_flag) begin
                r_cnt <= 3'd0;
            end else if (w_cnt_inc >= 4'(DEBOUNCE)) begin
                r_flag <= ~r_flag;
                r_cnt  <= 3'd0;
            end else if (r_cnt != 3'd7) begin
                r_cnt <= w_cnt_inc[2:0];
            end
        end
    end
endmodule

// File: rtl/obj_sensor_scheduler.sv
// Time-multiplexes one ranging unit over four directions, thresholds each distance
// and debounces the per-direction presence flags; front is rescanned while held.
module obj_sensor_scheduler
    import obj_pkg::*;
#(
    parameter int DIST_W   = 12,
    parameter int TIMEOUT  = 1000,
    parameter int GAP      = 16,
    parameter int DEBOUNCE = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DIST_W-1:0]     threshold,
    obj_sensor_scheduler_if.master rng,
    output logic                  front_sensor,
    output logic                  right_sensor,
    output logic                  back_sensor,
    output logic                  left_sensor,
    output logic                  scan_done,
    output logic                  timeout_err
);
    localparam int CNT_MAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    sched_state_t     r_state;
    sched_state_t     w_state_n;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_sel;
    logic [1:0]       r_pos;
    logic             r_ins;
    logic             r_scan_done;
    logic             r_timeout_err;

    logic             w_commit;
    logic             w_timeout;
    logic             w_advance;
    logic             w_cnt_clr;
    logic             w_hit;
    logic [1:0]       w_next_pos;
    logic [3:0]       w_upd;
    logic [3:0]       w_flag;

    assign w_hit      = rng.rng_done && (rng.rng_dist != '0) && (rng.rng_dist < threshold);
    assign w_next_pos = r_pos + 2'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_commit  = 1'b0;
        w_timeout = 1'b0;
        w_advance = 1'b0;
        w_cnt_clr = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) w_state_n = S_REQ;
            end
            S_REQ: begin
                if (rng.rng_ack) begin
                    w_state_n = S_WAIT;
                    w_cnt_clr = 1'b1;
                end
            end
            S_WAIT: begin
                // A done arriving on the last allowed cycle still counts as a real result.
                if (rng.rng_done) begin
                    w_commit  = 1'b1;
                    w_cnt_clr = 1'b1;
                    w_state_n = S_GAP;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_commit  = 1'b1;
                    w_timeout = 1'b1;
                    w_cnt_clr = 1'b1;
                    w_state_n = S_GAP;
                end
            end
            S_GAP: begin
                if (r_cnt == CNT_W'(GAP - 1)) begin
                    w_advance = 1'b1;
                    w_cnt_clr = 1'b1;
                    w_state_n = enable ? S_REQ : S_IDLE;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || w_cnt_clr) begin
            r_cnt <= '0;
        end else if (r_state == S_WAIT || r_state == S_GAP) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // r_pos tracks the round position; an inserted front slot leaves it untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel <= DIR_F;
            r_pos <= DIR_F;
            r_ins <= 1'b0;
        end else if (w_advance) begin
            if (!r_ins && front_sensor && r_sel != DIR_F && w_next_pos != DIR_F) begin
                r_sel <= DIR_F;
                r_ins <= 1'b1;
            end else begin
                r_sel <= w_next_pos;
                r_pos <= w_next_pos;
                r_ins <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan_done   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_scan_done   <= w_commit && (r_sel == DIR_L);
            r_timeout_err <= w_timeout;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_dir
        assign w_upd[gi] = w_commit && (r_sel == 2'(gi));
        obj_debounce #(
            .DEBOUNCE(DEBOUNCE)
        ) u_deb (
            .clk  (clk),
            .reset(reset),
            .upd  (w_upd[gi]),
            .hit  (w_hit),
            .flag (w_flag[gi])
        );
    end

    assign rng.rng_req  = (r_state == S_REQ);
    assign rng.rng_sel  = r_sel;
    assign front_sensor = w_flag[DIR_F];
    assign right_sensor = w_flag[DIR_R];
    assign back_sensor  = w_flag[DIR_B];
    assign left_sensor  = w_flag[DIR_L];
    assign scan_done    = r_scan_done;
    assign timeout_err  = r_timeout_err;
endmodule

// File: tb/tb_obj_sensor_scheduler.sv
// Directed bench for obj_sensor_scheduler with a behavioural ranging unit.
module tb_obj_sensor_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [11:0] threshold;
    logic        front_sensor, right_sensor, back_sensor, left_sensor;
    logic        scan_done, timeout_err;
    int          total = 0;
    int          bad   = 0;

    localparam int HOLD_SEL   [25] = '{0,1,2,3,0,1,2,3,0,1,0,2,0,3,0,1,0,2,0,3,0,1,2,3,0};
    localparam int HOLD_FRONT [25] = '{0,0,0,0,0,0,0,0,1,1,1,1,1,1,1,1,1,1,1,1,0,0,0,0,0};

    obj_sensor_scheduler_if #(.DIST_W(12)) rng();

    obj_sensor_scheduler #(
        .DIST_W(12), .TIMEOUT(1000), .GAP(16), .DEBOUNCE(3)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .threshold(threshold), .rng(rng),
        .front_sensor(front_sensor), .right_sensor(right_sensor),
        .back_sensor(back_sensor), .left_sensor(left_sensor),
        .scan_done(scan_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        enable        = 1'b0;
        threshold     = 12'd200;
        rng.rng_ack   = 1'b0;
        rng.rng_done  = 1'b0;
        rng.rng_dist  = 12'd0;
        reset         = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // Serves one measurement; done_dly = 0 means the unit never answers.
    task automatic meas(input logic [11:0] df, input logic [11:0] dother, input int done_dly,
                        output logic [1:0] sel, output logic scan, output logic terr,
                        output int wcyc);
        int n;
        n = 0;
        while (rng.rng_req !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (rng.rng_req !== 1'b1) begin
            bad++;
            $display("FAIL req_wait: rng_req=%b after %0d cycles, required 1", rng.rng_req, n);
        end
        sel = rng.rng_sel;
        rng.rng_ack = 1'b1;
        @(negedge clk);
        rng.rng_ack = 1'b0;
        wcyc = 0;
        if (done_dly == 0) begin
            while (timeout_err !== 1'b1 && wcyc < 1100) begin
                @(negedge clk);
                wcyc++;
            end
        end else begin
            repeat (done_dly - 1) @(negedge clk);
            rng.rng_done = 1'b1;
            rng.rng_dist = (sel == 2'd0) ? df : dother;
            @(negedge clk);
            rng.rng_done = 1'b0;
            rng.rng_dist = 12'd0;
        end
        scan = scan_done;
        terr = timeout_err;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (3) @(negedge clk);
        total++;
        if (rng.rng_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", rng.rng_req); end
        total++;
        if (rng.rng_sel !== 2'd0) begin bad++; $display("FAIL reset_sel: got %0d want 0", rng.rng_sel); end
        total++;
        if ({front_sensor, right_sensor, back_sensor, left_sensor} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 0000", {front_sensor, right_sensor, back_sensor, left_sensor});
        end
        total++;
        if ({scan_done, timeout_err} !== 2'b00) begin
            bad++; $display("FAIL reset_pulses: got %b want 00", {scan_done, timeout_err});
        end
    endtask

    task automatic test_normal();
        logic [1:0] sel;
        logic       scan, terr;
        int         wc;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            meas(12'd500, 12'd500, 5, sel, scan, terr, wc);
            total++;
            if (sel !== 2'(i % 4)) begin bad++; $display("FAIL normal_sel[%0d]: got %0d want %0d", i, sel, i % 4); end
            total++;
            if (scan !== (i == 3)) begin bad++; $display("FAIL normal_scan[%0d]: got %b want %b", i, scan, (i == 3)); end
        end
        total++;
        if ({front_sensor, right_sensor, back_sensor, left_sensor} !== 4'b0000) begin
            bad++;
            $display("FAIL normal_flags: got %b want 0000", {front_sensor, right_sensor, back_sensor, left_sensor});
        end
    endtask

    task automatic test_front_hold();
        logic [1:0] sel;
        logic       scan, terr;
        int         wc;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 25; i++) begin
            meas((i < 16) ? 12'd100 : 12'd300, 12'd500, 5, sel, scan, terr, wc);
            total++;
            if (sel !== 2'(HOLD_SEL[i])) begin
                bad++; $display("FAIL hold_sel[%0d]: got %0d want %0d", i, sel, HOLD_SEL[i]);
            end
            total++;
            if (front_sensor !== 1'(HOLD_FRONT[i])) begin
                bad++; $display("FAIL hold_front[%0d]: got %b want %0d", i, front_sensor, HOLD_FRONT[i]);
            end
        end
    endtask

    task automatic test_alternate();
        logic [1:0] sel;
        logic       scan, terr;
        int         wc;
        do_reset();
        enable = 1'b1;
        for (int r = 0; r < 6; r++) begin
            for (int s = 0; s < 4; s++) begin
                meas((r % 2 == 0) ? 12'd100 : 12'd300, 12'd500, 5, sel, scan, terr, wc);
                if (s == 0) begin
                    total++;
                    if (front_sensor !== 1'b0) begin bad++; $display("FAIL alt_front[%0d]: got %b want 0", r, front_sensor); end
                end
            end
        end
    endtask

    task automatic test_timeout();
        logic [1:0] sel;
        logic       scan, terr;
        int         wc;
        do_reset();
        enable = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int s = 0; s < 4; s++) begin
                meas(12'd100, 12'd500, (r == 2 && s == 0) ? 0 : 5, sel, scan, terr, wc);
                if (r == 2 && s == 0) begin
                    total++;
                    if (wc !== 1000) begin bad++; $display("FAIL to_latency: got %0d want 1000", wc); end
                    total++;
                    if (terr !== 1'b1) begin bad++; $display("FAIL to_pulse: got %b want 1", terr); end
                    total++;
                    if (scan !== 1'b0) begin bad++; $display("FAIL to_scan: got %b want 0", scan); end
                    @(negedge clk);
                    total++;
                    if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_width: got %b want 0", timeout_err); end
                end
                if (r == 2 && s == 1) begin
                    total++;
                    if (sel !== 2'd1) begin bad++; $display("FAIL to_next_sel: got %0d want 1", sel); end
                end
                if (r == 3 && s == 0) begin
                    total++;
                    if (front_sensor !== 1'b0) begin bad++; $display("FAIL to_miss: got %b want 0", front_sensor); end
                end
            end
        end
    endtask

    task automatic test_done_at_timeout();
        logic [1:0] sel;
        logic       scan, terr;
        int         wc;
        do_reset();
        enable = 1'b1;
        meas(12'd50, 12'd500, 1000, sel, scan, terr, wc);
        total++;
        if (terr !== 1'b0) begin bad++; $display("FAIL edge_terr: got %b want 0", terr); end
        @(negedge clk);
        total++;
        if (timeout_err !== 1'b0) begin bad++; $display("FAIL edge_terr_late: got %b want 0", timeout_err); end
        for (int i = 1; i < 9; i++) meas(12'd50, 12'd500, 5, sel, scan, terr, wc);
        total++;
        if (front_sensor !== 1'b1) begin bad++; $display("FAIL edge_hit_counted: got %b want 1", front_sensor); end
    endtask

    task automatic test_bounds(input logic [11:0] bad_dist);
        logic [1:0]  sel;
        logic        scan, terr;
        int          wc;
        logic [11:0] df;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 17; i++) begin
            df = (i == 4) ? bad_dist : 12'd199;
            meas(df, 12'd500, 5, sel, scan, terr, wc);
            if (i % 4 == 0) begin
                total++;
                if (front_sensor !== (i == 16)) begin
                    bad++; $display("FAIL bounds_%0d[%0d]: got %b want %b", bad_dist, i / 4, front_sensor, (i == 16));
                end
            end
        end
    endtask

    task automatic test_reset_in_wait();
        logic [1:0] sel;
        logic       scan, terr;
        int         wc;
        int         n;
        n = 0;
        while (rng.rng_req !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (rng.rng_sel !== 2'd1) begin bad++; $display("FAIL rst_pre_sel: got %0d want 1", rng.rng_sel); end
        rng.rng_ack = 1'b1;
        @(negedge clk);
        rng.rng_ack = 1'b0;
        total++;
        if (front_sensor !== 1'b1) begin bad++; $display("FAIL rst_pre_front: got %b want 1", front_sensor); end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (rng.rng_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", rng.rng_req); end
        total++;
        if (rng.rng_sel !== 2'd0) begin bad++; $display("FAIL rst_sel: got %0d want 0", rng.rng_sel); end
        total++;
        if ({front_sensor, right_sensor, back_sensor, left_sensor, scan_done, timeout_err} !== 6'd0) begin
            bad++; $display("FAIL rst_outs: got %b want 000000",
                            {front_sensor, right_sensor, back_sensor, left_sensor, scan_done, timeout_err});
        end
        reset = 1'b0;
        meas(12'd500, 12'd500, 5, sel, scan, terr, wc);
        total++;
        if (sel !== 2'd0) begin bad++; $display("FAIL rst_restart_sel: got %0d want 0", sel); end
    endtask

    task automatic test_enable_gap();
        logic [1:0] sel;
        logic       scan, terr;
        int         wc;
        int         req_hi;
        do_reset();
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            meas(12'd500, 12'd500, 5, sel, scan, terr, wc);
            total++;
            if (sel !== 2'(k)) begin bad++; $display("FAIL en_sel[%0d]: got %0d want %0d", k, sel, k); end
            enable = 1'b0;
            req_hi = 0;
            repeat (40) begin
                @(negedge clk);
                if (rng.rng_req !== 1'b0) req_hi++;
            end
            total++;
            if (req_hi !== 0) begin bad++; $display("FAIL en_idle_req[%0d]: got %0d high cycles want 0", k, req_hi); end
            enable = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_front_hold();
        test_alternate();
        test_timeout();
        test_done_at_timeout();
        test_bounds(12'd0);
        test_bounds(12'd200);
        test_reset_in_wait();
        test_enable_gap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
